// File: rtl/rw_request_scheduler_pkg.sv
// Shared controller types for the read/write request scheduler.
//   frontend_command_t : queued command (bank/row/col address plus tag)
//   cmd_addr_t         : address-only view used by the write shadow table
//   sched_state_e      : scheduler direction state
package rw_request_scheduler_pkg;

   localparam int unsigned BANK_W = 3;
   localparam int unsigned ROW_W  = 14;
   localparam int unsigned COL_W  = 10;
   localparam int unsigned TAG_W  = 8;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [TAG_W-1:0]  tag;
   } frontend_command_t;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } cmd_addr_t;

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_WRITE = 2'd1,
      S_TURN  = 2'd2
   } sched_state_e;

   // Strip the tag so only the memory location is compared.
   function automatic cmd_addr_t cmd_addr(input frontend_command_t c);
      return {c.bank, c.row, c.col};
   endfunction

endpackage

// File: rtl/rw_request_scheduler_if.sv
// Bus between the request FIFOs, the scheduler and the backend.
//   master : scheduler side (pops FIFOs, issues commands)
//   slave  : environment side (FIFOs, write-push snoop, backend ready)
interface rw_request_scheduler_if;
   import rw_request_scheduler_pkg::*;

   logic              i_rd_empty;
   frontend_command_t i_rd_data;
   logic              o_rd_pop;
   logic              i_wr_empty;
   frontend_command_t i_wr_data;
   logic              o_wr_pop;
   logic              i_wr_push;
   frontend_command_t i_wr_push_data;
   logic              i_wr_flush;
   logic              o_raw_flag;
   logic              o_cmd_valid;
   logic              i_cmd_ready;
   frontend_command_t o_cmd;
   logic              o_error;

   modport master (
      input  i_rd_empty, i_rd_data, i_wr_empty, i_wr_data, i_wr_push,
             i_wr_push_data, i_wr_flush, i_cmd_ready,
      output o_rd_pop, o_wr_pop, o_raw_flag, o_cmd_valid, o_cmd, o_error
   );

   modport slave (
      output i_rd_empty, i_rd_data, i_wr_empty, i_wr_data, i_wr_push,
             i_wr_push_data, i_wr_flush, i_cmd_ready,
      input  o_rd_pop, o_wr_pop, o_raw_flag, o_cmd_valid, o_cmd, o_error
   );

endinterface

// File: rtl/rw_request_scheduler_write_addr_cam.sv
// Circular shadow table of addresses sitting in the write FIFO, with a
// parallel compare against the read FIFO head.
//   push/push_addr : write accepted into the write FIFO
//   pop            : oldest write leaves the write FIFO
//   lookup_*       : read head to compare, hit_c is combinational
//   error          : sticky overflow/underflow
module write_addr_cam
   import rw_request_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  cmd_addr_t push_addr,
   input  logic      pop,
   input  logic      lookup_valid,
   input  cmd_addr_t lookup_addr,
   output logic      hit_c,
   output logic      error
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   cmd_addr_t        tbl [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count;
   logic             full, empty, push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // A push into a full table still lands when the oldest entry leaves this cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   // Parallel compare against every live entry.
   always_comb begin
      hit_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (lookup_valid && vld[PTR_W'(i)] && (tbl[PTR_W'(i)] == lookup_addr))
            hit_c = 1'b1;
      end
   end

   // Pointers, valid bits, occupancy and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         vld   <= '0;
         error <= 1'b0;
      end else begin
         if (pop_ok) begin
            vld[rptr] <= 1'b0;
            rptr      <= nxt(rptr);
         end
         // Ordered after the clear so a same-slot push wins.
         if (push_ok) begin
            vld[wptr] <= 1'b1;
            wptr      <= nxt(wptr);
         end
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
         if ((push && full && !pop) || (pop && empty))
            error <= 1'b1;
      end
   end

   // Address storage; validity is tracked separately so no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok)
         tbl[wptr] <= push_addr;
   end

endmodule

// File: rtl/rw_request_scheduler.sv
// Read/write request scheduler: drains the read and write FIFOs into a single
// command slot, prefers reads, inserts turnaround gaps on direction changes
// and holds reads that hit a pending write.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (master)   : FIFO pops, write-push snoop, command slot, raw/error flags
module rw_request_scheduler
   import rw_request_scheduler_pkg::*;
#(
   parameter int unsigned WR_DEPTH    = 8,
   parameter int unsigned TURN_CYCLES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   rw_request_scheduler_if.master bus
);

   sched_state_e      state, target;
   logic [1:0]        turn_cnt;
   frontend_command_t cmd_q;
   logic              cmd_valid_q, raw_q;
   logic              raw_hit, slot_free, want_read, rd_pop, wr_pop, go_turn;

   write_addr_cam #(.DEPTH(WR_DEPTH)) u_cam (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .push         (bus.i_wr_push),
      .push_addr    (cmd_addr(bus.i_wr_push_data)),
      .pop          (wr_pop),
      .lookup_valid (!bus.i_rd_empty),
      .lookup_addr  (cmd_addr(bus.i_rd_data)),
      .hit_c        (raw_hit),
      .error        (bus.o_error)
   );

   // Pop decision; the FIFOs need the strobe in the same cycle as the head.
   always_comb begin
      slot_free = !cmd_valid_q || bus.i_cmd_ready;
      want_read = !bus.i_rd_empty && !raw_hit && !bus.i_wr_flush;
      rd_pop    = 1'b0;
      wr_pop    = 1'b0;
      go_turn   = 1'b0;
      case (state)
         S_READ: begin
            rd_pop  = slot_free && want_read;
            go_turn = !want_read && !bus.i_wr_empty;
         end
         S_WRITE: begin
            // An eligible read preempts further writes.
            go_turn = bus.i_wr_empty || want_read;
            wr_pop  = slot_free && !go_turn;
         end
         default: ;
      endcase
   end

   // Strobes forced low while reset is held.
   assign bus.o_rd_pop    = rd_pop && i_rst_n;
   assign bus.o_wr_pop    = wr_pop && i_rst_n;
   assign bus.o_cmd_valid = cmd_valid_q;
   assign bus.o_cmd       = cmd_q;
   assign bus.o_raw_flag  = raw_q;

   // Direction FSM, turnaround counter and command slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_READ;
         target      <= S_READ;
         turn_cnt    <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         raw_q       <= 1'b0;
      end else begin
         raw_q <= raw_hit;
         if (slot_free) begin
            cmd_valid_q <= rd_pop || wr_pop;
            if (rd_pop)
               cmd_q <= bus.i_rd_data;
            else if (wr_pop)
               cmd_q <= bus.i_wr_data;
         end
         case (state)
            S_READ: begin
               if (go_turn) begin
                  state    <= S_TURN;
                  target   <= S_WRITE;
                  turn_cnt <= '0;
               end
            end
            S_WRITE: begin
               if (go_turn) begin
                  state    <= S_TURN;
                  target   <= S_READ;
                  turn_cnt <= '0;
               end
            end
            S_TURN: begin
               if (turn_cnt == 2'(TURN_CYCLES - 1)) begin
                  state    <= target;
                  turn_cnt <= '0;
               end else begin
                  turn_cnt <= turn_cnt + 2'd1;
               end
            end
            default: state <= S_READ;
         endcase
      end
   end

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Randomized bench for rw_request_scheduler against a queue-based model of
// the FIFOs, the direction policy and the command slot.
module tb_rw_request_scheduler;
   import rw_request_scheduler_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TURN  = 2;

   logic clk;
   logic rst_n;
   rw_request_scheduler_if bus ();

   rw_request_scheduler #(.WR_DEPTH(DEPTH), .TURN_CYCLES(TURN)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Model state: FIFO contents, direction, turnaround, command slot.
   frontend_command_t rq[$];
   frontend_command_t wq[$];
   int                mode;       // 0 = reading, 1 = writing
   int                turn_left;
   int                target;
   bit                m_valid;
   frontend_command_t m_cmd;
   bit                m_raw;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Small address space so read/write collisions are common.
   function automatic frontend_command_t rand_cmd();
      frontend_command_t c;
      c.bank = BANK_W'($urandom_range(0, 1));
      c.row  = ROW_W'($urandom_range(0, 1));
      c.col  = COL_W'($urandom_range(0, 1));
      c.tag  = TAG_W'($urandom);
      return c;
   endfunction

   function automatic bit same_addr(input frontend_command_t a, input frontend_command_t b);
      return (a.bank == b.bank) && (a.row == b.row) && (a.col == b.col);
   endfunction

   task automatic idle_inputs();
      bus.i_rd_empty     = 1'b1;
      bus.i_rd_data      = '0;
      bus.i_wr_empty     = 1'b1;
      bus.i_wr_data      = '0;
      bus.i_wr_push      = 1'b0;
      bus.i_wr_push_data = '0;
      bus.i_wr_flush     = 1'b0;
      bus.i_cmd_ready    = 1'b0;
   endtask

   task automatic model_reset();
      rq.delete();
      wq.delete();
      mode      = 0;
      turn_left = 0;
      target    = 0;
      m_valid   = 1'b0;
      m_cmd     = '0;
      m_raw     = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd_pop"},    bus.o_rd_pop,    0);
      check({tag, "_wr_pop"},    bus.o_wr_pop,    0);
      check({tag, "_cmd_valid"}, bus.o_cmd_valid, 0);
      check({tag, "_cmd"},       bus.o_cmd,       0);
      check({tag, "_raw"},       bus.o_raw_flag,  0);
      check({tag, "_error"},     bus.o_error,     0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs_zero("rst");
      check("rst_state", dut.state, S_READ);
      check("rst_count", dut.u_cam.count, 0);
      rst_n = 1'b1;
   endtask

   // One clock of random traffic; knobs are percentages.
   task automatic step(input int p_rd, input int p_wr, input int p_flush, input int p_ready);
      bit                ready, flush, do_rd, do_wr, hit, free, want_rd, e_rd, e_wr;
      frontend_command_t wcmd;
      @(negedge clk);
      check("cmd_valid", bus.o_cmd_valid, m_valid);
      if (m_valid) check("cmd", bus.o_cmd, m_cmd);
      check("raw_flag", bus.o_raw_flag, m_raw);
      check("error", bus.o_error, 0);
      check("tbl_count", dut.u_cam.count, wq.size());

      ready = ($urandom_range(0, 99) < p_ready);
      flush = ($urandom_range(0, 99) < p_flush);
      do_rd = (rq.size() < 6) && ($urandom_range(0, 99) < p_rd);
      do_wr = (wq.size() < DEPTH) && ($urandom_range(0, 99) < p_wr);
      wcmd  = rand_cmd();

      bus.i_cmd_ready    = ready;
      bus.i_wr_flush     = flush;
      bus.i_rd_empty     = (rq.size() == 0);
      bus.i_rd_data      = (rq.size() != 0) ? rq[0] : '0;
      bus.i_wr_empty     = (wq.size() == 0);
      bus.i_wr_data      = (wq.size() != 0) ? wq[0] : '0;
      bus.i_wr_push      = do_wr;
      bus.i_wr_push_data = wcmd;
      #1;

      // A read hazards against any write still queued behind the scheduler.
      hit = 1'b0;
      if (rq.size() != 0)
         foreach (wq[i]) if (same_addr(wq[i], rq[0])) hit = 1'b1;
      free    = !m_valid || ready;
      want_rd = (rq.size() != 0) && !hit && !flush;
      e_rd    = 1'b0;
      e_wr    = 1'b0;
      if (turn_left == 0) begin
         if (mode == 0) e_rd = free && want_rd;
         else           e_wr = free && (wq.size() != 0) && !want_rd;
      end
      check("rd_pop", bus.o_rd_pop, e_rd);
      check("wr_pop", bus.o_wr_pop, e_wr);

      if (free) begin
         m_valid = e_rd || e_wr;
         if (e_rd) m_cmd = rq[0];
         if (e_wr) m_cmd = wq[0];
      end
      m_raw = hit;
      if (turn_left > 0) begin
         turn_left--;
         if (turn_left == 0) mode = target;
      end else if (mode == 0 && !want_rd && wq.size() != 0) begin
         turn_left = TURN;
         target    = 1;
      end else if (mode == 1 && (wq.size() == 0 || want_rd)) begin
         turn_left = TURN;
         target    = 0;
      end
      if (e_rd) void'(rq.pop_front());
      if (e_wr) void'(wq.pop_front());
      if (do_rd) rq.push_back(rand_cmd());
      if (do_wr) wq.push_back(wcmd);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      do_reset();

      // Read-only burst with backend always ready.
      repeat (4)   step(100, 0, 0, 100);
      repeat (10)  step(0, 0, 0, 100);
      // Mixed traffic, then flush-heavy, then a backend stall and release.
      repeat (400) step(40, 40, 10, 70);
      repeat (200) step(30, 50, 60, 80);
      repeat (12)  step(50, 50, 0, 0);
      repeat (30)  step(0, 0, 0, 100);
      repeat (300) step(50, 50, 20, 50);

      // Reset in the middle of a write drain.
      do_reset();
      repeat (12) step(0, 100, 100, 30);
      @(posedge clk);
      #2;
      check("pre_rst_count_nz", dut.u_cam.count != 0, 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      check("async_rst_state", dut.state, S_READ);
      check("async_rst_count", dut.u_cam.count, 0);
      do_reset();

      // Shadow-table overflow: nine pushes with nothing leaving.
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k == 8) begin
            check("ovf_err_at_8", bus.o_error, 0);
            check("ovf_count_at_8", dut.u_cam.count, 8);
         end
         bus.i_wr_push      = 1'b1;
         bus.i_wr_push_data = rand_cmd();
      end
      @(negedge clk);
      bus.i_wr_push = 1'b0;
      check("ovf_err", bus.o_error, 1);
      check("ovf_count", dut.u_cam.count, 8);
      check("ovf_no_pop", bus.o_wr_pop, 0);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rw_request_scheduler.md
RW_REQUEST_SCHEDULER -- requirements
Module: rw_request_scheduler

Interface
REQ-001 SHALL have parameter WR_DEPTH, default 8; write request FIFO depth and shadow address table entry count.
REQ-002 SHALL have parameter TURN_CYCLES, default 1; idle cycles inserted on each read/write direction change (range 1..3).
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rd_empty  input  1  read request FIFO empty.
REQ-006 SHALL have port i_rd_data  input  frontend_command_t  read FIFO head, first-word fall-through.
REQ-007 SHALL have port o_rd_pop  output  1  active-high one-cycle pop strobe to the read FIFO.
REQ-008 SHALL have port i_wr_empty  input  1  write request FIFO empty.
REQ-009 SHALL have port i_wr_data  input  frontend_command_t  write FIFO head, first-word fall-through.
REQ-010 SHALL have port o_wr_pop  output  1  active-high one-cycle pop strobe to the write FIFO.
REQ-011 SHALL have port i_wr_push  input  1  snoop of accepted pushes into the write FIFO.
REQ-012 SHALL have port i_wr_push_data  input  frontend_command_t  command being pushed.
REQ-013 SHALL have port i_wr_flush  input  1  write flush flag from the write FIFO.
REQ-014 SHALL have port o_raw_flag  output  1  read-after-write hazard at read FIFO head.
REQ-015 SHALL have port o_cmd_valid  output  1  issued command valid.
REQ-016 SHALL have port i_cmd_ready  input  1  backend accepts command.
REQ-017 SHALL have port o_cmd  output  frontend_command_t  issued command.
REQ-018 SHALL have port o_error  output  1  sticky shadow-table overflow/underflow.

Function
REQ-019 SHALL keep a WR_DEPTH-entry circular shadow table of {bank,row,col}: write on i_wr_push, retire oldest on o_wr_pop; simultaneous push and pop both take effect, count unchanged.
REQ-020 SHALL compare {bank,row,col} of i_rd_data against all valid shadow entries when !i_rd_empty; o_raw_flag registered, asserted the cycle after a hit, deasserted the cycle after no hit.
REQ-021 SHALL define slot_free = !o_cmd_valid || i_cmd_ready; pops occur only when slot_free, at most one of o_rd_pop/o_wr_pop per cycle.
REQ-022 SHALL load o_cmd with the popped FIFO head and set o_cmd_valid on the edge ending the pop cycle (latency 1); o_cmd/o_cmd_valid SHALL hold while o_cmd_valid && !i_cmd_ready.
REQ-023 SHALL implement FSM S_READ, S_WRITE, S_TURN; reset state S_READ.
REQ-024 S_READ: pop read when !i_rd_empty, no RAW hit, !i_wr_flush; go S_TURN (target WRITE) when (i_wr_flush || i_rd_empty || RAW hit) && !i_wr_empty.
REQ-025 S_WRITE: pop write when !i_wr_empty; go S_TURN (target READ) when i_wr_empty, or !i_wr_flush && !i_rd_empty && no RAW hit.
REQ-026 S_TURN: no pops for TURN_CYCLES cycles (counter), then enter target state.
REQ-027 SHALL set o_error on push with table full without same-cycle pop, or o_wr_pop with table empty; overflowing push ignored.
REQ-028 Read and write both pending, flush low, no hazard: reads SHALL win.

Reset
REQ-029 On i_rst_n low: o_cmd_valid=0, o_cmd=0, o_raw_flag=0, o_error=0, o_rd_pop=o_wr_pop=0, table count 0, pointers 0, FSM S_READ, turn counter 0; mid-transfer command discarded.

Structure
REQ-030 frontend_command_t, address-field widths and FSM state enum SHALL live in the shared controller package.
REQ-031 Shadow table with compare logic SHALL be sub-module write_addr_cam.

Verification
REQ-032 Read-only traffic, ready=1: 4 reads -> o_rd_pop cycles 0..3, o_cmd_valid cycles 1..4, no o_wr_pop.
REQ-033 Push write bank0/row5/col8, then read same address -> o_raw_flag=1 next cycle, read held, S_TURN 1 cycle, write issued, raw clears, read issued after second turnaround.
REQ-034 i_wr_flush=1 with 3 writes, 2 reads pending -> 3 writes issued back-to-back before any read.
REQ-035 i_cmd_ready=0 for 5 cycles with valid command -> o_cmd stable, zero pops, resumes on ready.
REQ-036 9 pushes with no pop (WR_DEPTH=8) -> o_error=1, table count 8.
REQ-037 Reset asserted mid-write-drain -> all outputs 0 asynchronously; post-reset state S_READ, table empty.
